// File: rtl/log_line_uart_tx.sv
// Formats one captured log word as "XXXXXXXX\r\n" (uppercase hex, MSB nibble first)
// and shifts it out on a UART 8N1 pin; line_transmitted paces the upstream FIFO.
module log_line_uart_tx #(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line_trans_en,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  line_transmitted,
  output logic                  tx,
  output logic                  busy,
  output logic                  overrun_err
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state;
  logic [CNT_W-1:0]      baud_cnt;
  logic [2:0]            bit_idx;
  logic [3:0]            char_idx;
  logic [DATA_WIDTH-1:0] shadow;
  logic [7:0]            shift;
  logic [3:0]            nibble;
  logic [7:0]            char_byte;

  always_comb begin
    nibble = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (char_idx[2:0] == i[2:0]) nibble = shadow[DATA_WIDTH-1-4*i -: 4];
    if (char_idx == 4'd8)      char_byte = 8'h0D;
    else if (char_idx == 4'd9) char_byte = 8'h0A;
    else if (nibble < 4'd10)   char_byte = 8'h30 + {4'h0, nibble};
    else                       char_byte = 8'h37 + {4'h0, nibble};
  end

  // tx is updated on the first count of each bit, so the pin lags the state by
  // one cycle; line_transmitted is raised in the IDLE cycle that absorbs that lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      baud_cnt         <= '0;
      bit_idx          <= '0;
      char_idx         <= '0;
      shadow           <= '0;
      shift            <= '0;
      tx               <= 1'b1;
      line_transmitted <= 1'b1;
      busy             <= 1'b0;
      overrun_err      <= 1'b0;
    end else if (state == IDLE) begin
      if (!line_transmitted) begin
        line_transmitted <= 1'b1;
        busy             <= 1'b0;
        if (line_trans_en) overrun_err <= 1'b1;
      end else if (line_trans_en) begin
        shadow           <= read_data;
        char_idx         <= '0;
        bit_idx          <= '0;
        baud_cnt         <= '0;
        line_transmitted <= 1'b0;
        busy             <= 1'b1;
        state            <= START;
      end
    end else begin
      if (line_trans_en) overrun_err <= 1'b1;
      baud_cnt <= (baud_cnt == CNT_LAST) ? '0 : baud_cnt + 1'b1;
      case (state)
        START: begin
          if (baud_cnt == '0) begin
            tx    <= 1'b0;
            shift <= char_byte;
          end
          if (baud_cnt == CNT_LAST) begin
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_cnt == '0) begin
            tx    <= shift[0];
            shift <= {1'b0, shift[7:1]};
          end
          if (baud_cnt == CNT_LAST) begin
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == '0) tx <= 1'b1;
          if (baud_cnt == CNT_LAST) begin
            if (char_idx == 4'd9) begin
              state <= IDLE;
            end else begin
              char_idx <= char_idx + 1'b1;
              state    <= START;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_log_line_uart_tx.sv
// Bench for log_line_uart_tx: a UART receiver decodes tx and lines are
// compared against hex strings computed from the captured words.
module tb_log_line_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_trans_en = 1'b0;
  logic [31:0] read_data = '0;
  logic        line_transmitted, tx, busy, overrun_err;

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] rx_q[$];

  log_line_uart_tx #(.DATA_WIDTH(32), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .line_trans_en(line_trans_en), .read_data(read_data),
    .line_transmitted(line_transmitted), .tx(tx), .busy(busy), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_char(input logic [31:0] w, input int idx);
    int unsigned n;
    if (idx == 8) return 8'h0D;
    if (idx == 9) return 8'h0A;
    n = (w >> (28 - 4 * idx)) % 16;
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  // UART receiver: every bit must hold for exactly CPB samples; framing is checked per char.
  initial begin : monitor
    logic [7:0] b;
    bit ok, abort;
    logic v0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        ok = 1; abort = 0; b = '0;
        for (int k = 0; k < 10 && !abort; k++) begin
          v0 = 1'bx;
          for (int s = 0; s < CPB && !abort; s++) begin
            if (k != 0 || s != 0) @(negedge clk);
            if (rst_n !== 1'b1) abort = 1;
            else if (s == 0) v0 = tx;
            else if (tx !== v0) ok = 0;
          end
          if (!abort) begin
            if (k == 0 && v0 !== 1'b0) ok = 0;
            if (k >= 1 && k <= 8) b[k-1] = v0;
            if (k == 9 && v0 !== 1'b1) ok = 0;
          end
        end
        if (!abort) begin
          check("frame", 32'(ok), 32'd1);
          rx_q.push_back(b);
        end
      end
    end
  end

  task automatic pulse(input logic [31:0] w);
    read_data     = w;
    line_trans_en = 1'b1;
    @(negedge clk);
    line_trans_en = 1'b0;
    read_data     = $urandom;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (line_transmitted !== 1'b1 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("idle_timeout", 32'(line_transmitted), 32'd1);
  endtask

  task automatic check_line(input string tag, input logic [31:0] w);
    logic [8:0] got;
    check({tag, "_len"}, rx_q.size(), 32'd10);
    for (int i = 0; i < 10; i++) begin
      got = (rx_q.size() > 0) ? {1'b0, rx_q.pop_front()} : 9'h1FF;
      check($sformatf("%s_c%0d", tag, i), 32'(got), 32'(exp_char(w, i)));
    end
    rx_q.delete();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cnt;
    logic [31:0] w;

    // T1 reset
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_lt", 32'(line_transmitted), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovr", 32'(overrun_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T2 single line with exact timing
    pulse(32'h1234ABCD);
    check("start_delay_tx", 32'(tx), 32'd1);
    check("lt_low", 32'(line_transmitted), 32'd0);
    check("busy_high", 32'(busy), 32'd1);
    @(negedge clk);
    check("start_bit_tx", 32'(tx), 32'd0);
    cnt = 1;
    while (line_transmitted === 1'b0 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check("lt_low_cycles", cnt, 32'd401);
    check("busy_after", 32'(busy), 32'd0);
    check_line("t2", 32'h1234ABCD);

    // T3 hex edge cases
    @(negedge clk);
    pulse(32'h09AF0F90);
    wait_idle();
    check_line("t3a", 32'h09AF0F90);
    pulse(32'h00000000);
    wait_idle();
    check_line("t3b", 32'h00000000);

    // Random words, each pulsed on the first idle cycle (back-to-back)
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      pulse(w);
      wait_idle();
      check_line($sformatf("rnd%0d", i), w);
    end
    check("no_ovr_b2b", 32'(overrun_err), 32'd0);

    // T4 overrun
    pulse(32'hDEADBEEF);
    repeat (49) @(negedge clk);
    pulse(32'h11111111);
    check("ovr_set", 32'(overrun_err), 32'd1);
    wait_idle();
    check_line("t4", 32'hDEADBEEF);
    repeat (60) @(negedge clk);
    check("ovr_no_extra", rx_q.size(), 32'd0);
    check("ovr_sticky", 32'(overrun_err), 32'd1);

    // T5 mid-line reset during char 3
    pulse(32'hDEADBEEF);
    repeat (125) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_tx", 32'(tx), 32'd1);
    check("mrst_lt", 32'(line_transmitted), 32'd1);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_ovr", 32'(overrun_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rx_q.delete();
    @(negedge clk);
    pulse(32'hCAFEF00D);
    wait_idle();
    check_line("t5", 32'hCAFEF00D);
    check("t5_ovr", 32'(overrun_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
